// File: rtl/poly_mac_pkg.sv
// Shared types and helpers for poly_mac.
// POLY_MAC_SAT_EN (optional macro) selects saturating instead of wrapping arithmetic.
package poly_mac_pkg;

  typedef enum logic [1:0] {StIdle, StAcc, StOut} state_e;

  localparam logic MODE_HORNER = 1'b0;
  localparam logic MODE_PSUM   = 1'b1;

  // Signed limit of a width-bit two's-complement value (upper or lower bound).
  function automatic logic signed [63:0] sat_limit(input int unsigned width, input logic upper);
    logic signed [63:0] one;
    one = 64'sd1;
    if (upper) return (one <<< (width - 1)) - one;
    else       return -(one <<< (width - 1));
  endfunction

endpackage

// File: rtl/poly_mac_dp.sv
// Datapath for poly_mac: full-precision multiply/add followed by wrap or saturate to ACC_W.
// POLY_MAC_SAT_EN defined: saturate each step; undefined: wrap modulo 2^ACC_W.
module poly_mac_dp
  import poly_mac_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned ACC_W = 24
) (
  input  logic                    first,
  input  logic                    mode,
  input  logic signed [ACC_W-1:0] acc,
  input  logic signed [DW-1:0]    x_q,
  input  logic signed [DW-1:0]    in_a,
  input  logic signed [DW-1:0]    in_x,
  output logic signed [ACC_W-1:0] acc_next,
  output logic                    ovf
);

  // Wide enough for acc*x + a without loss.
  localparam int unsigned FW = ACC_W + DW + 1;
  localparam logic signed [FW-1:0] MaxV = FW'(sat_limit(ACC_W, 1'b1));
  localparam logic signed [FW-1:0] MinV = FW'(sat_limit(ACC_W, 1'b0));

  logic signed [FW-1:0] a_ext, x_ext, xq_ext, acc_ext, prod_ax, full;

  // Compute one accumulation step at full precision and reduce it.
  always_comb begin
    a_ext   = {{(FW-DW){in_a[DW-1]}}, in_a};
    x_ext   = {{(FW-DW){in_x[DW-1]}}, in_x};
    xq_ext  = {{(FW-DW){x_q[DW-1]}}, x_q};
    acc_ext = {{(FW-ACC_W){acc[ACC_W-1]}}, acc};
    prod_ax = a_ext * x_ext;
    if (first) full = (mode == MODE_PSUM) ? prod_ax : a_ext;
    else       full = (mode == MODE_PSUM) ? acc_ext + prod_ax : acc_ext * xq_ext + a_ext;
    ovf = (full > MaxV) || (full < MinV);
`ifdef POLY_MAC_SAT_EN
    if (full > MaxV)      acc_next = MaxV[ACC_W-1:0];
    else if (full < MinV) acc_next = MinV[ACC_W-1:0];
    else                  acc_next = full[ACC_W-1:0];
`else
    acc_next = full[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/poly_mac.sv
// Horner / product-sum multiply-accumulate with valid/ready handshake.
// POLY_MAC_SAT_EN (optional macro) makes arithmetic saturate; default wraps.
module poly_mac
  import poly_mac_pkg::*;
#(
  parameter int unsigned DW      = 8,
  parameter int unsigned ACC_W   = 24,
  parameter int unsigned MAX_LEN = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mode,
  input  logic signed [DW-1:0]    in_a,
  input  logic signed [DW-1:0]    in_x,
  input  logic                    valid_in,
  input  logic                    last_in,
  output logic                    in_ready,
  output logic                    valid_out,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] result,
  output logic                    overflow,
  output logic                    len_err
);

  localparam int unsigned CW = $clog2(MAX_LEN + 1);

  state_e                  state_q;
  logic signed [ACC_W-1:0] acc_q, acc_nxt;
  logic signed [DW-1:0]    x_q;
  logic                    mode_q, ovf_q, len_err_q, dp_ovf;
  logic [CW-1:0]           cnt_q, cnt_nxt;
  logic                    first, accept, is_last;

  // Beat qualification and end-of-transaction detection.
  always_comb begin
    first   = (state_q == StIdle);
    accept  = valid_in && in_ready;
    cnt_nxt = first ? CW'(1) : cnt_q + CW'(1);
    is_last = last_in || (cnt_nxt == CW'(MAX_LEN));
  end

  poly_mac_dp #(
    .DW    (DW),
    .ACC_W (ACC_W)
  ) u_dp (
    .first    (first),
    .mode     (first ? mode : mode_q),
    .acc      (acc_q),
    .x_q      (x_q),
    .in_a     (in_a),
    .in_x     (in_x),
    .acc_next (acc_nxt),
    .ovf      (dp_ovf)
  );

  // FSM, accumulator, beat counter and sticky flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      x_q       <= '0;
      mode_q    <= MODE_HORNER;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StAcc: begin
          if (accept) begin
            acc_q <= acc_nxt;
            cnt_q <= cnt_nxt;
            if (first) begin
              mode_q <= mode;
              x_q    <= in_x;
              ovf_q  <= dp_ovf;
            end else begin
              ovf_q  <= ovf_q | dp_ovf;
            end
            if (is_last) begin
              state_q   <= StOut;
              len_err_q <= !last_in;
            end else begin
              state_q   <= StAcc;
            end
          end
        end
        StOut: if (out_ready) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q != StOut);
  assign valid_out = (state_q == StOut);
  assign result    = acc_q;
  assign overflow  = ovf_q;
  assign len_err   = len_err_q;

endmodule

// File: tb/tb_poly_mac.sv
// Directed scoreboard bench for poly_mac (DW=8, ACC_W=24, MAX_LEN=16).
module tb_poly_mac;

  localparam int DW = 8, ACC_W = 24, MAX_LEN = 16;

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic                    mode = 1'b0;
  logic signed [DW-1:0]    in_a = '0;
  logic signed [DW-1:0]    in_x = '0;
  logic                    valid_in = 1'b0;
  logic                    last_in = 1'b0;
  logic                    in_ready;
  logic                    valid_out;
  logic                    out_ready = 1'b0;
  logic signed [ACC_W-1:0] result;
  logic                    overflow;
  logic                    len_err;

  poly_mac #(.DW(DW), .ACC_W(ACC_W), .MAX_LEN(MAX_LEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .in_a      (in_a),
    .in_x      (in_x),
    .valid_in  (valid_in),
    .last_in   (last_in),
    .in_ready  (in_ready),
    .valid_out (valid_out),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .len_err   (len_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [63:0] res;
    logic               ovf;
    logic               lerr;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int errs = 0;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic signed [63:0] r, input logic o, input logic le);
    exp_t e;
    e.res = r; e.ovf = o; e.lerr = le;
    sb.push_back(e);
  endtask

  // Offer one beat at the falling edge; it is taken on the following rising edge.
  task automatic beat(input logic m, input int a, input int x, input logic l);
    @(negedge clk);
    mode = m; in_a = a[DW-1:0]; in_x = x[DW-1:0]; last_in = l; valid_in = 1'b1;
    chk("in_ready_beat", {63'd0, in_ready}, 64'sd1);
    @(posedge clk);
  endtask

  // Check result one cycle after the last beat, optionally stall, then handshake.
  task automatic collect(input string tag, input int stall);
    exp_t e;
    @(negedge clk);
    valid_in = 1'b0; last_in = 1'b0;
    chk({tag, "_valid_lat1"}, {63'd0, valid_out}, 64'sd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'sd0, 64'sd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_result"}, result, e.res);
    chk({tag, "_overflow"}, {63'd0, overflow}, {63'd0, e.ovf});
    chk({tag, "_len_err"}, {63'd0, len_err}, {63'd0, e.lerr});
    if (stall > 0) begin
      // Offer a beat while stalled; it must not be taken.
      mode = 1'b0; in_a = 8'sd99; last_in = 1'b1; valid_in = 1'b1;
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({tag, "_stall_valid"}, {63'd0, valid_out}, 64'sd1);
      chk({tag, "_stall_ready"}, {63'd0, in_ready}, 64'sd0);
      chk({tag, "_stall_result"}, result, e.res);
    end
    valid_in = 1'b0; last_in = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_valid_clr"}, {63'd0, valid_out}, 64'sd0);
    chk({tag, "_ready_back"}, {63'd0, in_ready}, 64'sd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chk("rst_valid", {63'd0, valid_out}, 64'sd0);
    chk("rst_result", result, 64'sd0);
    chk("rst_overflow", {63'd0, overflow}, 64'sd0);
    chk("rst_len_err", {63'd0, len_err}, 64'sd0);
    chk("rst_ready", {63'd0, in_ready}, 64'sd1);

    // Horner 2x^2+3x+4 at x=5; mode/x changes after the first beat are ignored
    push(64'sd69, 1'b0, 1'b0);
    beat(1'b0, 2, 5, 1'b0);
    beat(1'b1, 3, 9, 1'b0);
    beat(1'b1, 4, -3, 1'b1);
    collect("horner69", 0);

    // Product-sum 1*2+3*4+5*6 with a 3-cycle output stall
    push(64'sd44, 1'b0, 1'b0);
    beat(1'b1, 1, 2, 1'b0);
    beat(1'b0, 3, 4, 1'b0);
    beat(1'b0, 5, 6, 1'b1);
    collect("psum44", 3);

    // Single-beat Horner
    push(64'sd7, 1'b0, 1'b0);
    beat(1'b0, 7, 0, 1'b1);
    collect("horner7", 0);

    // Horner overflow: 127x^3+127x^2+127x+127 at x=127
`ifdef POLY_MAC_SAT_EN
    push(64'sd8388607, 1'b1, 1'b0);
`else
    push(-64'sd6226176, 1'b1, 1'b0);
`endif
    beat(1'b0, 127, 127, 1'b0);
    beat(1'b0, 127, 0, 1'b0);
    beat(1'b0, 127, 0, 1'b0);
    beat(1'b0, 127, 0, 1'b1);
    collect("horner_ovf", 0);

    // MAX_LEN beats with no last_in; overflow must be cleared
    push(64'sd16, 1'b0, 1'b1);
    for (int i = 0; i < MAX_LEN; i++) beat(1'b1, 1, 1, 1'b0);
    collect("len_err", 0);

    // Next transaction clears len_err; idle gap in ACC holds state
    push(64'sd26, 1'b0, 1'b0);
    beat(1'b1, 2, 3, 1'b0);
    @(negedge clk);
    valid_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("gap_valid", {63'd0, valid_out}, 64'sd0);
    beat(1'b1, 4, 5, 1'b1);
    collect("psum26_gap", 0);

    // Reset mid-transaction discards it
    beat(1'b1, 1, 1, 1'b0);
    beat(1'b1, 1, 1, 1'b0);
    @(negedge clk);
    valid_in = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("midrst_result", result, 64'sd0);
    repeat (3) begin
      @(negedge clk);
      chk("midrst_valid", {63'd0, valid_out}, 64'sd0);
    end
    push(64'sd6, 1'b0, 1'b0);
    beat(1'b1, 2, 3, 1'b1);
    collect("psum6", 0);

    chk("sb_drained", sb.size(), 64'sd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
